// File: rtl/i2s_rx_pkg.sv
// i2s_rx_pkg: shared definitions for the I2S capture path.
//   cap_state_e       - capture FSM states
//   SyncDepth         - synchronizer flops ahead of the edge register
//   sample_bits_legal - accepted SAMPLE_BITS values
package i2s_rx_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSync,
        StLeft,
        StRight
    } cap_state_e;

    localparam int unsigned SyncDepth = 2;

    function automatic bit sample_bits_legal(int unsigned bits);
        return (bits == 16) || (bits == 24) || (bits == 32);
    endfunction

endpackage

// File: rtl/sample_byte_serializer.sv
// sample_byte_serializer: holds one stereo frame and writes it out one byte
// per clock, least-significant byte first, left channel before right.
//   clk, rst_n  - clock, asynchronous active-low reset
//   load        - capture frame (only asserted while not busy)
//   frame       - {right, left}, each BYTES*8 bits wide
//   fifo_full   - downstream full; stalls output without loss
//   wr_en       - write strobe, holding & ~fifo_full
//   wr_data     - byte being written (zero when wr_en is low)
//   busy        - a frame is still held, including its last-byte cycle
module sample_byte_serializer #(
    parameter int unsigned BYTES = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [16*BYTES-1:0]   frame,
    input  logic                  fifo_full,
    output logic                  wr_en,
    output logic [7:0]            wr_data,
    output logic                  busy
);

    localparam int unsigned NumBytes = 2 * BYTES;
    localparam int unsigned IdxW     = $clog2(NumBytes);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NumBytes - 1);

    logic [16*BYTES-1:0] hold_q;
    logic [IdxW-1:0]     idx_q;
    logic                holding_q;

    assign wr_en   = holding_q & ~fifo_full;
    assign wr_data = wr_en ? hold_q[7:0] : 8'h00;
    assign busy    = holding_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q    <= '0;
            idx_q     <= '0;
            holding_q <= 1'b0;
        end else if (load) begin
            hold_q    <= frame;
            idx_q     <= '0;
            holding_q <= 1'b1;
        end else if (wr_en) begin
            // Shift the next byte into the low lane; index only tracks the end.
            hold_q <= hold_q >> 8;
            if (idx_q == LastIdx) begin
                holding_q <= 1'b0;
                idx_q     <= '0;
            end else begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2s_rx_packer.sv
// i2s_rx_packer: I2S slave receiver. Oversamples bclk/lrck/sdata on clk_i,
// deserializes stereo frames and writes them little-endian into the out FIFO.
//   clk_i, reset_n_i        - system clock, asynchronous active-low reset
//   enable_i                - capture enable
//   i2s_bclk_i/lrck_i/sdata_i - asynchronous I2S pads (lrck 0 = left)
//   wr_out_fifo_*           - FIFO write port (clock, strobe, byte, full)
//   synced_o                - locked to frame boundaries
//   overflow_o              - sticky: completed frame dropped while busy
//   frame_err_o             - sticky: short slot seen while locked
//   frame_cnt_o             - frames accepted by the serializer, wraps
module i2s_rx_packer
    import i2s_rx_pkg::*;
#(
    parameter int unsigned SAMPLE_BITS = 24
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        enable_i,
    input  logic        i2s_bclk_i,
    input  logic        i2s_lrck_i,
    input  logic        i2s_sdata_i,
    output logic        wr_out_fifo_clk_o,
    output logic        wr_out_fifo_en_o,
    output logic [7:0]  wr_out_fifo_data_o,
    input  logic        wr_out_fifo_full_i,
    output logic        synced_o,
    output logic        overflow_o,
    output logic        frame_err_o,
    output logic [15:0] frame_cnt_o
);

    localparam int unsigned BYTES = SAMPLE_BITS / 8;
    localparam int unsigned CntW  = $clog2(SAMPLE_BITS + 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(SAMPLE_BITS);
    localparam logic [CntW-1:0] LastCnt = CntW'(SAMPLE_BITS - 1);

    if (!sample_bits_legal(SAMPLE_BITS)) begin : g_bad_sample_bits
        $error("SAMPLE_BITS must be 16, 24 or 32");
    end

    assign wr_out_fifo_clk_o = clk_i;

    // Pad synchronizers: all three pads see the same depth so lrck/sdata
    // taken from the edge register line up with the bclk rising strobe.
    logic [SyncDepth-1:0][2:0] sync_q;
    logic [2:0]                edge_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sync_q <= '0;
            edge_q <= '0;
        end else begin
            sync_q <= {sync_q[SyncDepth-2:0], {i2s_bclk_i, i2s_lrck_i, i2s_sdata_i}};
            edge_q <= sync_q[SyncDepth-1];
        end
    end

    logic bclk_rise;
    logic lrck_smp;
    logic sdata_smp;

    assign bclk_rise = sync_q[SyncDepth-1][2] & ~edge_q[2];
    assign lrck_smp  = edge_q[1];
    assign sdata_smp = edge_q[0];

    // Slot tracking runs regardless of enable so lrck_last_q is never stale
    // when capture starts.
    logic                   lrck_last_q;
    logic [CntW-1:0]        bit_cnt_q;
    logic [SAMPLE_BITS-1:0] shift_q;
    logic [SAMPLE_BITS-1:0] shift_next;
    logic                   bit_take;
    logic                   slot_change;
    logic                   slot_full;

    assign bit_take    = bit_cnt_q < FullCnt;
    assign slot_change = bclk_rise & (lrck_smp != lrck_last_q);
    // Counts the bit on the change strobe, which closes the previous slot.
    assign slot_full   = bit_cnt_q >= LastCnt;
    assign shift_next  = bit_take ? {shift_q[SAMPLE_BITS-2:0], sdata_smp} : shift_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            lrck_last_q <= 1'b0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
        end else if (bclk_rise) begin
            lrck_last_q <= lrck_smp;
            shift_q     <= shift_next;
            if (slot_change) begin
                bit_cnt_q <= '0;
            end else if (bit_take) begin
                bit_cnt_q <= bit_cnt_q + 1'b1;
            end
        end
    end

    // Capture FSM
    cap_state_e state_q, state_d;
    logic       latch_left;
    logic       frame_done;
    logic       slot_err;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        latch_left = 1'b0;
        frame_done = 1'b0;
        slot_err   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (enable_i) state_d = StSync;
            end
            StSync: begin
                if (slot_change && !lrck_smp) state_d = StLeft;
            end
            StLeft: begin
                if (slot_change) begin
                    if (slot_full) begin
                        latch_left = 1'b1;
                        state_d    = StRight;
                    end else begin
                        slot_err = 1'b1;
                        state_d  = StSync;
                    end
                end
            end
            StRight: begin
                if (slot_change) begin
                    if (slot_full) begin
                        frame_done = 1'b1;
                        state_d    = StLeft;
                    end else begin
                        slot_err = 1'b1;
                        state_d  = StSync;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        if (!enable_i) begin
            state_d    = StIdle;
            latch_left = 1'b0;
            frame_done = 1'b0;
            slot_err   = 1'b0;
        end
    end

    assign synced_o = (state_q == StLeft) || (state_q == StRight);

    logic [SAMPLE_BITS-1:0] left_q;
    logic                   ser_busy;
    logic                   handoff;
    logic                   overflow_q;
    logic                   frame_err_q;
    logic [15:0]            frame_cnt_q;

    // A serializer still writing its last byte counts as busy.
    assign handoff = frame_done & ~ser_busy;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            left_q      <= '0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            if (latch_left)            left_q      <= shift_next;
            if (frame_done && ser_busy) overflow_q <= 1'b1;
            if (slot_err)              frame_err_q <= 1'b1;
            if (handoff)               frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign overflow_o  = overflow_q;
    assign frame_err_o = frame_err_q;
    assign frame_cnt_o = frame_cnt_q;

    sample_byte_serializer #(
        .BYTES (BYTES)
    ) u_serializer (
        .clk       (clk_i),
        .rst_n     (reset_n_i),
        .load      (handoff),
        .frame     ({shift_next, left_q}),
        .fifo_full (wr_out_fifo_full_i),
        .wr_en     (wr_out_fifo_en_o),
        .wr_data   (wr_out_fifo_data_o),
        .busy      (ser_busy)
    );

endmodule

// File: tb/tb_i2s_rx_packer.sv
// tb_i2s_rx_packer: directed-random bench for i2s_rx_packer. Drives a
// continuous I2S stream (bclk = clk/8, lrck/sdata change on bclk fall,
// one-bclk data delay) and compares FIFO bytes and flags to a frame model.
module tb_i2s_rx_packer;

    localparam int SB = 24;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        bclk;
    logic        lrck;
    logic        sdata;
    logic        full;
    logic        wr_clk;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic        synced;
    logic        overflow;
    logic        frame_err;
    logic [15:0] frame_cnt;

    i2s_rx_packer #(
        .SAMPLE_BITS (SB)
    ) dut (
        .clk_i              (clk),
        .reset_n_i          (reset_n),
        .enable_i           (enable),
        .i2s_bclk_i         (bclk),
        .i2s_lrck_i         (lrck),
        .i2s_sdata_i        (sdata),
        .wr_out_fifo_clk_o  (wr_clk),
        .wr_out_fifo_en_o   (wr_en),
        .wr_out_fifo_data_o (wr_data),
        .wr_out_fifo_full_i (full),
        .synced_o           (synced),
        .overflow_o         (overflow),
        .frame_err_o        (frame_err),
        .frame_cnt_o        (frame_cnt)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          full_viol = 0;
    logic [7:0]  got_q[$];
    int          got_cyc[$];
    logic [7:0]  exp_q[$];
    int          checked = 0;
    logic        carry = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (wr_en === 1'b1) begin
            got_q.push_back(wr_data);
            got_cyc.push_back(cyc);
            if (full === 1'b1) full_viol++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Model: an accepted frame becomes L bytes LSB-first, then R bytes.
    task automatic push_frame(input logic [31:0] l, input logic [31:0] r);
        for (int b = 0; b < SB / 8; b++) exp_q.push_back(l[8*b +: 8]);
        for (int b = 0; b < SB / 8; b++) exp_q.push_back(r[8*b +: 8]);
    endtask

    task automatic chk_stream(input string tag);
        logic [31:0] obs;
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = checked; i < exp_q.size(); i++) begin
            obs = (i < got_q.size()) ? {24'h0, got_q[i]} : 32'hDEAD_BEEF;
            chk($sformatf("%s_byte%0d", tag, i), obs, {24'h0, exp_q[i]});
        end
        checked = exp_q.size();
    endtask

    // One lrck slot of nbits bclks; bit 0 carries the previous slot's last bit.
    task automatic slot(input bit lr, input int nbits, input logic [31:0] word);
        for (int k = 0; k < nbits; k++) begin
            bclk = 1'b0;
            lrck = lr;
            if (k == 0) sdata = carry;
            else if (k - 1 < SB) sdata = word[SB - k];
            else sdata = 1'($urandom_range(0, 1));
            #40;
            bclk = 1'b1;
            #40;
        end
        carry = (nbits - 1 < SB) ? word[SB - nbits] : 1'($urandom_range(0, 1));
    endtask

    task automatic wait_bytes(input int n, input string tag);
        int budget;
        budget = 4000;
        while (got_q.size() < n && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        if (got_q.size() < n) chk({tag, "_timeout"}, got_q.size(), n);
    endtask

    function automatic logic [31:0] rnd();
        return $urandom & 32'h00FF_FFFF;
    endfunction

    logic [31:0] l1, r1, l2, r2, l3, r3, l4, r4, l5, r5, l6, l7, r7, l9, r9, l11, r11;
    int          s0;

    initial begin
        reset_n = 1'b0;
        enable  = 1'b0;
        bclk    = 1'b0;
        lrck    = 1'b0;
        sdata   = 1'b0;
        full    = 1'b0;
        l1 = 32'h123456; r1 = 32'hABCDEF;
        l2 = rnd(); r2 = rnd(); l3 = rnd(); r3 = rnd(); l4 = rnd(); r4 = rnd();
        l5 = rnd(); r5 = rnd(); l6 = rnd(); l7 = rnd(); r7 = rnd();
        l9 = rnd(); r9 = rnd(); l11 = rnd(); r11 = rnd();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_en", wr_en, 0);
        chk("rst_data", wr_data, 0);
        chk("rst_synced", synced, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        @(negedge clk);
        #1;
        chk("fifo_clk_low", wr_clk, clk);
        @(posedge clk);
        #1;
        chk("fifo_clk_high", wr_clk, clk);
        reset_n = 1'b1;
        enable  = 1'b1;
        #3;

        // Basic frame
        slot(1'b1, 32, rnd());
        slot(1'b0, 32, l1);
        chk("basic_synced", synced, 1);
        slot(1'b1, 32, r1);
        slot(1'b0, 32, l2);
        push_frame(l1, r1);
        chk_stream("basic");
        chk("basic_consecutive", (got_cyc.size() >= 6) ? got_cyc[5] - got_cyc[0] : -1, 5);
        chk("basic_frame_cnt", frame_cnt, 1);

        // Backpressure after the 2nd byte of frame 2
        slot(1'b1, 32, r2);
        fork
            slot(1'b0, 32, l3);
            begin
                wait_bytes(8, "bp");
                #1;
                full = 1'b1;
                s0 = got_q.size();
                repeat (10) @(posedge clk);
                #1;
                chk("bp_stall_no_write", got_q.size(), s0);
                full = 1'b0;
            end
        join
        push_frame(l2, r2);
        chk_stream("bp");
        chk("bp_frame_cnt", frame_cnt, 2);
        slot(1'b1, 32, r3);

        // Overflow: full held over two frame completions
        full = 1'b1;
        slot(1'b0, 32, l4);
        slot(1'b1, 32, r4);
        slot(1'b0, 32, l5);
        chk("ovf_flag", overflow, 1);
        chk("ovf_no_write", got_q.size(), exp_q.size());
        chk("ovf_frame_cnt", frame_cnt, 3);
        @(posedge clk);
        #1;
        full = 1'b0;
        repeat (20) @(posedge clk);
        push_frame(l3, r3);
        chk_stream("ovf_drain");
        slot(1'b1, 32, r5);
        slot(1'b0, 32, l6);
        push_frame(l5, r5);
        chk_stream("post_ovf");
        chk("post_ovf_sticky", overflow, 1);
        chk("post_ovf_frame_cnt", frame_cnt, 4);

        // Short right slot
        slot(1'b1, 16, rnd());
        slot(1'b0, 32, rnd());
        chk("short_frame_err", frame_err, 1);
        chk("short_synced", synced, 0);
        slot(1'b1, 32, rnd());
        slot(1'b0, 32, l7);
        chk("short_resynced", synced, 1);
        slot(1'b1, 32, r7);
        slot(1'b0, 32, rnd());
        push_frame(l7, r7);
        chk_stream("short");
        chk("short_frame_cnt", frame_cnt, 5);

        // Enable mid right slot
        enable = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("dis_synced", synced, 0);
        fork
            slot(1'b1, 32, rnd());
            #(16 * 80) enable = 1'b1;
        join
        slot(1'b0, 32, l9);
        slot(1'b1, 32, r9);
        chk("mid_no_write", got_q.size(), exp_q.size());

        // Reset after the 3rd byte of frame 9
        fork
            slot(1'b0, 32, rnd());
            begin
                wait_bytes(exp_q.size() + 3, "rst_mid");
                #1;
                chk("pre_rst_frame_cnt", frame_cnt, 6);
                reset_n = 1'b0;
                #1;
                chk("mid_rst_en", wr_en, 0);
                chk("mid_rst_synced", synced, 0);
                chk("mid_rst_overflow", overflow, 0);
                chk("mid_rst_frame_err", frame_err, 0);
                chk("mid_rst_frame_cnt", frame_cnt, 0);
                repeat (3) @(posedge clk);
                #1;
                reset_n = 1'b1;
            end
        join
        for (int b = 0; b < SB / 8; b++) exp_q.push_back(l9[8*b +: 8]);
        chk_stream("mid_partial");
        slot(1'b1, 32, rnd());
        slot(1'b0, 32, l11);
        slot(1'b1, 32, r11);
        slot(1'b0, 32, rnd());
        push_frame(l11, r11);
        chk_stream("after_rst");
        chk("after_rst_frame_cnt", frame_cnt, 1);
        chk("after_rst_synced", synced, 1);
        chk("en_while_full", full_viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
